// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous memory between the fetch and data ports.
// Optional perf counters are enabled with `define ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_stall
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_conflict,
  output logic [31:0]       perf_busy
`endif
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
  localparam logic [7:0] SMAX   = 8'(STARVE_MAX);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] starve, starve_n;
  logic       rd_pend, rd_pend_n;
  logic       own_d, own_d_n;
  logic       idle, if_win, d_win, grant, rd_grant;

  always_comb begin
    idle     = ~rst & (state == IDLE);
    if_win   = idle & if_req & (~d_req | (starve == SMAX));
    d_win    = idle & d_req & ~if_win;
    grant    = if_win | d_win;
    rd_grant = if_win | (d_win & ~d_we);
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rd_pend_n = rd_pend;
    own_d_n   = own_d;
    case (state)
      IDLE: begin
        // the pending rvalid (if any) is delivered this cycle
        rd_pend_n = 1'b0;
        if (rd_grant) begin
          rd_pend_n = 1'b1;
          own_d_n   = d_win;
          if (MEM_LAT > 1) begin
            state_n = WAIT;
            cnt_n   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_n = IDLE;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    starve_n = starve;
    if (~if_req | if_win)
      starve_n = 8'd0;
    else if (starve != SMAX)
      starve_n = starve + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      starve  <= 8'd0;
      rd_pend <= 1'b0;
      own_d   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      starve  <= starve_n;
      rd_pend <= rd_pend_n;
      own_d   <= own_d_n;
    end
  end

  always_comb begin
    if_gnt    = if_win;
    d_gnt     = d_win;
    if_stall  = ~rst & if_req & ~if_win;
    mem_en    = grant;
    mem_wen   = d_win & d_we;
    mem_addr  = d_win ? d_addr : (if_win ? if_addr : '0);
    mem_wdata = d_win ? d_wdata : '0;
    if_rvalid = idle & rd_pend & ~own_d;
    d_rvalid  = idle & rd_pend & own_d;
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict <= 32'd0;
      perf_busy     <= 32'd0;
    end else begin
      if (state == IDLE && if_req && d_req)
        perf_conflict <= perf_conflict + 32'd1;
      if (state == WAIT && (if_req || d_req))
        perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule
